// File: rtl/scan_ctrl_pkg.sv
// Shared types and constants for the scan chain controller.
package scan_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SHIFT_IN  = 2'd1,
    CAPTURE   = 2'd2,
    SHIFT_OUT = 2'd3
  } state_t;

  localparam int DEF_CHAIN_LEN  = 32;
  localparam int DEF_CAP_CYCLES = 1;
  localparam int DEF_CNT_W      = 16;

  // Width of the shift bit counter; one spare bit above clog2 of the chain length.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/scan_ctrl_cmp.sv
// Masked response compare and saturating failed-test counter.
module scan_ctrl_cmp
  import scan_ctrl_pkg::*;
#(
  parameter int W     = DEF_CHAIN_LEN,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             RSTB,
  input  logic             cmp_en,
  input  logic [W-1:0]     resp,
  input  logic [W-1:0]     exp_v,
  input  logic [W-1:0]     mask,
  input  logic             done,
  input  logic             clr_cnt,
  output logic             fail,
  output logic [CNT_W-1:0] fail_cnt
);

  // register the masked compare on the final unload edge; held until the next one
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      fail <= 1'b0;
    end else if (cmp_en) begin
      fail <= |((resp ^ exp_v) & mask);
    end
  end

  // count failed tests while DONE is high; clear wins, saturate at all-ones
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      fail_cnt <= '0;
    end else if (clr_cnt) begin
      fail_cnt <= '0;
    end else if (done && fail && (fail_cnt != '1)) begin
      fail_cnt <= fail_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan chain test sequencer: serial load, functional capture, serial unload,
// masked compare against an expected vector.
// Optional build macro SCAN_CTRL_OVERLAP_EN: a START seen during CAPTURE
// queues the next test so its load overlaps the current unload.
//
// state     | meaning
// IDLE      | waiting for START, chain untouched (SE=0)
// SHIFT_IN  | SE=1, pattern shifted in MSB first, CHAIN_LEN edges
// CAPTURE   | SE=0, functional capture, CAP_CYCLES edges
// SHIFT_OUT | SE=1, response unloaded from SO, CHAIN_LEN edges
module scan_chain_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN  = DEF_CHAIN_LEN,
  parameter int CAP_CYCLES = DEF_CAP_CYCLES,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                 CLK,
  input  logic                 RSTB,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic                 CLR_CNT,
  input  logic [CHAIN_LEN-1:0] PAT_IN,
  input  logic [CHAIN_LEN-1:0] EXP_IN,
  input  logic [CHAIN_LEN-1:0] MASK_IN,
  input  logic                 SO,
  output logic                 SE,
  output logic                 SI,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [CHAIN_LEN-1:0] RESP_OUT,
  output logic                 FAIL,
  output logic [CNT_W-1:0]     FAIL_CNT
);

  localparam int CB = cnt_width(CHAIN_LEN);

  state_t               state;
  logic [CB-1:0]        bit_cnt;
  logic [3:0]           cap_cnt;
  logic [CHAIN_LEN-1:0] sh_pat;
  logic [CHAIN_LEN-2:0] resp_sh;
  logic [CHAIN_LEN-1:0] exp_q;
  logic [CHAIN_LEN-1:0] mask_q;
  logic [CHAIN_LEN-1:0] resp_next;
  logic                 cmp_en;
`ifdef SCAN_CTRL_OVERLAP_EN
  logic [CHAIN_LEN-1:0] nxt_pat;
  logic [CHAIN_LEN-1:0] nxt_exp;
  logic [CHAIN_LEN-1:0] nxt_mask;
  logic                 nxt_vld;
`endif

  // response as it will look after this edge's SO sample; strobe on the last unload edge
  always_comb begin
    resp_next = {resp_sh, SO};
    cmp_en    = (state == SHIFT_OUT) && (bit_cnt == '0) && !ABORT;
  end

  // sequencer: state, chain controls, pattern and response shift registers
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state    <= IDLE;
      SE       <= 1'b0;
      SI       <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      RESP_OUT <= '0;
      bit_cnt  <= '0;
      cap_cnt  <= '0;
      sh_pat   <= '0;
      resp_sh  <= '0;
      exp_q    <= '0;
      mask_q   <= '0;
`ifdef SCAN_CTRL_OVERLAP_EN
      nxt_pat  <= '0;
      nxt_exp  <= '0;
      nxt_mask <= '0;
      nxt_vld  <= 1'b0;
`endif
    end else begin
      DONE <= 1'b0;
      if (ABORT && (state != IDLE)) begin
        // abandon the test; previous result and count stay visible
        state <= IDLE;
        SE    <= 1'b0;
        SI    <= 1'b0;
        BUSY  <= 1'b0;
`ifdef SCAN_CTRL_OVERLAP_EN
        nxt_vld <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (START && !ABORT) begin
              exp_q   <= EXP_IN;
              mask_q  <= MASK_IN;
              SI      <= PAT_IN[CHAIN_LEN-1];
              sh_pat  <= PAT_IN << 1;
              SE      <= 1'b1;
              BUSY    <= 1'b1;
              bit_cnt <= CB'(CHAIN_LEN - 1);
              state   <= SHIFT_IN;
            end
          end

          SHIFT_IN: begin
            if (bit_cnt == '0) begin
              state   <= CAPTURE;
              SE      <= 1'b0;
              SI      <= 1'b0;
              cap_cnt <= 4'(CAP_CYCLES - 1);
            end else begin
              bit_cnt <= bit_cnt - CB'(1);
              SI      <= sh_pat[CHAIN_LEN-1];
              sh_pat  <= sh_pat << 1;
            end
          end

          CAPTURE: begin
`ifdef SCAN_CTRL_OVERLAP_EN
            if (START) begin
              nxt_pat  <= PAT_IN;
              nxt_exp  <= EXP_IN;
              nxt_mask <= MASK_IN;
              nxt_vld  <= 1'b1;
            end
`endif
            if (cap_cnt == '0) begin
              state   <= SHIFT_OUT;
              SE      <= 1'b1;
              bit_cnt <= CB'(CHAIN_LEN - 1);
              resp_sh <= '0;
`ifdef SCAN_CTRL_OVERLAP_EN
              // the queued pattern goes in while the response comes out
              if (START) begin
                SI     <= PAT_IN[CHAIN_LEN-1];
                sh_pat <= PAT_IN << 1;
              end else if (nxt_vld) begin
                SI     <= nxt_pat[CHAIN_LEN-1];
                sh_pat <= nxt_pat << 1;
              end else begin
                SI     <= 1'b0;
                sh_pat <= '0;
              end
`else
              SI <= 1'b0;
`endif
            end else begin
              cap_cnt <= cap_cnt - 4'd1;
            end
          end

          SHIFT_OUT: begin
            resp_sh <= resp_next[CHAIN_LEN-2:0];
            if (bit_cnt == '0) begin
              RESP_OUT <= resp_next;
              DONE     <= 1'b1;
              SI       <= 1'b0;
              SE       <= 1'b0;
`ifdef SCAN_CTRL_OVERLAP_EN
              if (nxt_vld) begin
                // next test is already in the chain: go straight to capture
                state   <= CAPTURE;
                cap_cnt <= 4'(CAP_CYCLES - 1);
                exp_q   <= nxt_exp;
                mask_q  <= nxt_mask;
                nxt_vld <= 1'b0;
              end else begin
                state <= IDLE;
                BUSY  <= 1'b0;
              end
`else
              state <= IDLE;
              BUSY  <= 1'b0;
`endif
            end else begin
              bit_cnt <= bit_cnt - CB'(1);
`ifdef SCAN_CTRL_OVERLAP_EN
              SI     <= sh_pat[CHAIN_LEN-1];
              sh_pat <= sh_pat << 1;
`else
              SI <= 1'b0;
`endif
            end
          end

          default: begin
            state <= IDLE;
            SE    <= 1'b0;
            SI    <= 1'b0;
            BUSY  <= 1'b0;
          end
        endcase
      end
    end
  end

  scan_ctrl_cmp #(
    .W     (CHAIN_LEN),
    .CNT_W (CNT_W)
  ) u_cmp (
    .CLK      (CLK),
    .RSTB     (RSTB),
    .cmp_en   (cmp_en),
    .resp     (resp_next),
    .exp_v    (exp_q),
    .mask     (mask_q),
    .done     (DONE),
    .clr_cnt  (CLR_CNT),
    .fail     (FAIL),
    .fail_cnt (FAIL_CNT)
  );

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl with an 8-cell chain whose capture inverts every cell.
module tb_scan_chain_ctrl;

  logic       CLK;
  logic       RSTB;
  logic       START;
  logic       ABORT;
  logic       CLR_CNT;
  logic [7:0] PAT_IN;
  logic [7:0] EXP_IN;
  logic [7:0] MASK_IN;
  logic       SO;
  logic       SE;
  logic       SI;
  logic       BUSY;
  logic       DONE;
  logic [7:0] RESP_OUT;
  logic       FAIL;
  logic [1:0] FAIL_CNT;

  logic [7:0] chain = '0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] pat;
    logic [7:0] ev;
    logic [7:0] mv;
    logic [7:0] resp;
    logic       fail;
    logic [1:0] cnt;
  } vec_t;

  vec_t vecs[6];

  logic [7:0]  r_si;
  logic [7:0]  r_resp;
  logic [16:0] r_se;
  int          r_done_t;
  logic        r_fail;
  logic        r_busy;
  logic        r_se_done;
  logic        r_pulse;
  logic [1:0]  r_cnt;

  scan_chain_ctrl #(
    .CHAIN_LEN  (8),
    .CAP_CYCLES (1),
    .CNT_W      (2)
  ) dut (
    .CLK      (CLK),
    .RSTB     (RSTB),
    .START    (START),
    .ABORT    (ABORT),
    .CLR_CNT  (CLR_CNT),
    .PAT_IN   (PAT_IN),
    .EXP_IN   (EXP_IN),
    .MASK_IN  (MASK_IN),
    .SO       (SO),
    .SE       (SE),
    .SI       (SI),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .RESP_OUT (RESP_OUT),
    .FAIL     (FAIL),
    .FAIL_CNT (FAIL_CNT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // chain model: shift when SE=1, capture loads the inverted cells when SE=0
  always @(posedge CLK) begin
    if (SE) chain <= {chain[6:0], SI};
    else    chain <= ~chain;
  end
  assign SO = chain[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // one complete test from IDLE; entered and left at a falling edge
  task automatic run_test(input logic [7:0] pat, input logic [7:0] ev,
                          input logic [7:0] mv, input bit clr_at_done);
    logic [16:0] se_seq;
    se_seq    = '0;
    r_si      = '0;
    r_done_t  = -1;
    r_busy    = 1'b1;
    r_se_done = 1'b1;
    PAT_IN  = pat;
    EXP_IN  = ev;
    MASK_IN = mv;
    START   = 1'b1;
    @(posedge CLK);
    for (int t = 0; t < 100; t++) begin
      @(negedge CLK);
      START = 1'b0;
      if (t < 8)  r_si[7-t] = SI;
      if (t < 17) se_seq[t] = SE;
      if (DONE) begin
        r_done_t  = t;
        r_busy    = BUSY;
        r_se_done = SE;
        break;
      end
      @(posedge CLK);
    end
    r_se   = se_seq;
    r_resp = RESP_OUT;
    r_fail = FAIL;
    if (clr_at_done) CLR_CNT = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    CLR_CNT = 1'b0;
    r_cnt   = FAIL_CNT;
    r_pulse = DONE;
  endtask

  initial begin
    int done_cnt;
    int d_t[$];
    logic [7:0] d_r[$];
    logic d_f[$];
    int exp_n;
    int exp_t[3];
    logic [7:0] exp_r[3];

    vecs[0] = '{pat: 8'hA5, ev: 8'h5A, mv: 8'hFF, resp: 8'h5A, fail: 1'b0, cnt: 2'd0};
    vecs[1] = '{pat: 8'hA5, ev: 8'h5B, mv: 8'hFF, resp: 8'h5A, fail: 1'b1, cnt: 2'd1};
    vecs[2] = '{pat: 8'hA5, ev: 8'h5B, mv: 8'hFE, resp: 8'h5A, fail: 1'b0, cnt: 2'd1};
    vecs[3] = '{pat: 8'h3C, ev: 8'h00, mv: 8'h00, resp: 8'hC3, fail: 1'b0, cnt: 2'd1};
    vecs[4] = '{pat: 8'h0F, ev: 8'h00, mv: 8'h0F, resp: 8'hF0, fail: 1'b0, cnt: 2'd1};
    vecs[5] = '{pat: 8'h81, ev: 8'hFE, mv: 8'h80, resp: 8'h7E, fail: 1'b1, cnt: 2'd2};

    RSTB = 1'b0; START = 1'b0; ABORT = 1'b0; CLR_CNT = 1'b0;
    PAT_IN = '0; EXP_IN = '0; MASK_IN = '0;
    repeat (3) @(negedge CLK);
    check("rst_se",   32'(SE),       32'd0);
    check("rst_si",   32'(SI),       32'd0);
    check("rst_busy", 32'(BUSY),     32'd0);
    check("rst_done", 32'(DONE),     32'd0);
    check("rst_resp", 32'(RESP_OUT), 32'd0);
    check("rst_fail", 32'(FAIL),     32'd0);
    check("rst_cnt",  32'(FAIL_CNT), 32'd0);
    RSTB = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < 6; i++) begin
      run_test(vecs[i].pat, vecs[i].ev, vecs[i].mv, 1'b0);
      check($sformatf("v%0d_done_t", i), 32'(r_done_t), 32'd17);
      check($sformatf("v%0d_si",     i), 32'(r_si),     32'(vecs[i].pat));
      check($sformatf("v%0d_se",     i), 32'(r_se),     32'h1FEFF);
      check($sformatf("v%0d_resp",   i), 32'(r_resp),   32'(vecs[i].resp));
      check($sformatf("v%0d_fail",   i), 32'(r_fail),   32'(vecs[i].fail));
      check($sformatf("v%0d_busy",   i), 32'(r_busy),   32'd0);
      check($sformatf("v%0d_se_end", i), 32'(r_se_done), 32'd0);
      check($sformatf("v%0d_pulse",  i), 32'(r_pulse),  32'd0);
      check($sformatf("v%0d_cnt",    i), 32'(r_cnt),    32'(vecs[i].cnt));
    end

    // abort at unload edge 3 (edge 13 after the START edge)
    PAT_IN = 8'h00; EXP_IN = 8'h00; MASK_IN = 8'hFF; START = 1'b1;
    @(posedge CLK);
    for (int t = 0; t <= 12; t++) begin
      @(negedge CLK);
      START = 1'b0;
      if (t == 12) begin
        check("abort_pre_se", 32'(SE), 32'd1);
        ABORT = 1'b1;
      end
      if (t < 12) @(posedge CLK);
    end
    @(posedge CLK);
    @(negedge CLK);
    ABORT = 1'b0;
    check("abort_se",   32'(SE),   32'd0);
    check("abort_si",   32'(SI),   32'd0);
    check("abort_busy", 32'(BUSY), 32'd0);
    done_cnt = 0;
    for (int t = 0; t < 25; t++) begin
      if (DONE) done_cnt++;
      @(negedge CLK);
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check("abort_resp",    32'(RESP_OUT), 32'h7E);
    check("abort_fail",    32'(FAIL),     32'd1);
    check("abort_cnt",     32'(FAIL_CNT), 32'd2);

    // ABORT in IDLE blocks START
    START = 1'b1; ABORT = 1'b1;
    @(negedge CLK);
    START = 1'b0; ABORT = 1'b0;
    check("idle_abort_busy", 32'(BUSY), 32'd0);
    @(negedge CLK);
    check("idle_abort_se", 32'(SE), 32'd0);

    run_test(8'hC3, 8'h3C, 8'hFF, 1'b0);
    check("post_abort_done_t", 32'(r_done_t), 32'd17);
    check("post_abort_resp",   32'(r_resp),   32'h3C);
    check("post_abort_fail",   32'(r_fail),   32'd0);
    check("post_abort_cnt",    32'(r_cnt),    32'd2);

    // async reset between shift edges 3 and 4
    PAT_IN = 8'hFF; EXP_IN = 8'h00; MASK_IN = 8'hFF; START = 1'b1;
    @(posedge CLK);
    for (int t = 0; t <= 4; t++) begin
      @(negedge CLK);
      START = 1'b0;
      if (t < 4) @(posedge CLK);
    end
    check("rst_mid_pre_se", 32'(SE), 32'd1);
    RSTB = 1'b0;
    #1;
    check("rst_mid_se", 32'(SE), 32'd0);
    check("rst_mid_all", 32'({SI, BUSY, DONE, FAIL, FAIL_CNT, RESP_OUT}), 32'd0);
    @(negedge CLK);
    RSTB = 1'b1;
    @(negedge CLK);
    run_test(8'hA5, 8'h5A, 8'hFF, 1'b0);
    check("rst_clean_done_t", 32'(r_done_t), 32'd17);
    check("rst_clean_si",     32'(r_si),     32'hA5);
    check("rst_clean_resp",   32'(r_resp),   32'h5A);
    check("rst_clean_fail",   32'(r_fail),   32'd0);
    check("rst_clean_cnt",    32'(r_cnt),    32'd0);

    // saturation of the 2-bit counter, then clear racing an increment
    for (int i = 0; i < 4; i++) begin
      run_test(8'hA5, 8'h00, 8'hFF, 1'b0);
      check($sformatf("sat%0d_fail", i), 32'(r_fail), 32'd1);
      check($sformatf("sat%0d_cnt",  i), 32'(r_cnt),  32'((i < 3) ? i + 1 : 3));
    end
    run_test(8'hA5, 8'h00, 8'hFF, 1'b1);
    check("clr_fail",     32'(r_fail),   32'd1);
    check("clr_cnt",      32'(r_cnt),    32'd0);
    check("clr_keep_resp", 32'(RESP_OUT), 32'h5A);
    check("clr_keep_fail", 32'(FAIL),     32'd1);

    // START during CAPTURE (edge 9) and in the first DONE cycle (edge 18)
`ifdef SCAN_CTRL_OVERLAP_EN
    exp_n = 3;
    exp_t = '{17, 26, 35};
    exp_r = '{8'hED, 8'hCB, 8'hA9};
`else
    exp_n = 2;
    exp_t = '{17, 35, 0};
    exp_r = '{8'hED, 8'hA9, 8'h00};
`endif
    PAT_IN = 8'h12; EXP_IN = 8'hED; MASK_IN = 8'hFF; START = 1'b1;
    @(posedge CLK);
    for (int t = 0; t < 60; t++) begin
      @(negedge CLK);
      START = 1'b0;
      if (t == 8) begin
        PAT_IN = 8'h34; EXP_IN = 8'hCB; START = 1'b1;
      end
      if (t == 17) begin
        PAT_IN = 8'h56; EXP_IN = 8'hA9; START = 1'b1;
      end
      if (DONE) begin
        d_t.push_back(t);
        d_r.push_back(RESP_OUT);
        d_f.push_back(FAIL);
      end
      @(posedge CLK);
    end
    @(negedge CLK);
    check("b2b_n_done", 32'(d_t.size()), 32'(exp_n));
    for (int i = 0; i < exp_n; i++) begin
      if (i < d_t.size()) begin
        check($sformatf("b2b%0d_t",    i), 32'(d_t[i]), 32'(exp_t[i]));
        check($sformatf("b2b%0d_resp", i), 32'(d_r[i]), 32'(exp_r[i]));
        check($sformatf("b2b%0d_fail", i), 32'(d_f[i]), 32'd0);
      end
    end
    check("b2b_idle_busy", 32'(BUSY), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
